digit_serial_adder: RTL and testbench

//  Parametrised multi-cycle adder/subtractor built from full-adder digit slices.

---
 rtl/digit_serial_adder.sv | 139 +++++++++++++
 tb/tb_digit_serial_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder/subtractor that processes DIGIT bits per clock, least
//   significant digit first, with the inter-digit carry held in a register.
//   One operation takes WIDTH/DIGIT BUSY cycles between the operand and
//   result handshakes.
//
// Parameters
//   WIDTH      operand/result width (>= 1)
//   DIGIT      bits per cycle (1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0)
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous reset, active-high
//   in_valid   operand request
//   in_ready   operands accepted (IDLE and not in reset)
//   a, b       operands
//   cin        carry-in (add mode only)
//   sub        0: a+b+cin, 1: a-b computed as a + ~b + 1
//   out_valid  result available (DONE)
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (in subtract mode 1 = no borrow)
//   ovf        two's-complement overflow
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;       // already inverted for subtraction
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;    // carry into the top bit of the current digit
  logic             last;
  logic             accept;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(N - 1));

  // One full-adder digit slice over the digit selected by the counter.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    a_d    = '0;
    b_d    = '0;
    d_sum  = '0;
    d_cout = 1'b0;
    d_cmsb = 1'b0;
    a_d    = a_r[cnt*DIGIT +: DIGIT];
    b_d    = b_r[cnt*DIGIT +: DIGIT];
    {d_cout, d_sum} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
    // The sum bit is a ^ b ^ carry_in, so the carry into the top bit falls out
    // of an XOR; this also works for DIGIT == 1, where it is the carry register.
    d_cmsb = d_sum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
  end

  // NOTE: the operand registers are pure datapath captured on accept and never
  // read outside BUSY, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          sum[cnt*DIGIT +: DIGIT] <= d_sum;
          carry                   <= d_cout;
          if (last) begin
            cout  <= d_cout;
            ovf   <= d_cmsb ^ d_cout;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  // Second set of stimulus for the bit-serial and single-cycle builds.
  logic        x_valid, x_cin, x_sub;
  logic [15:0] x_a, x_b;
  logic        x_rdy = 1'b1;
  logic        r1_in_ready, r1_out_valid, r1_cout, r1_ovf;
  logic        r16_in_ready, r16_out_valid, r16_cout, r16_ovf;
  logic [15:0] r1_sum, r16_sum;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r1_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub), .out_valid(r1_out_valid),
    .out_ready(x_rdy), .sum(r1_sum), .cout(r1_cout), .ovf(r1_ovf)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r16_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub), .out_valid(r16_out_valid),
    .out_ready(x_rdy), .sum(r16_sum), .cout(r16_cout), .ovf(r16_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: {cout, ovf, sum}
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] bb;
    logic [16:0] r;
    logic        v;
    bb = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, bb} + {16'd0, (ms ? 1'b1 : mc)};
    v  = (ma[15] == bb[15]) && (r[15] != ma[15]);
    return {r[16], v, r[15:0]};
  endfunction

  // One operation on the DIGIT=4 build with latency check; operands are
  // scrambled right after acceptance to show they no longer matter.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts, input logic [15:0] es,
                        input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      a = ~ta; b = ~tb_; cin = ~tc; sub = ~ts;
      lat++;
    end while (!out_valid && lat < 40);
    check({tag, "_lat"}, lat - 1, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 1'b0);
  endtask

  // Same operation on the DIGIT=1 (N=16) and DIGIT=16 (N=1) builds together.
  task automatic run_multi(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tc, input logic ts, input logic [17:0] exp);
    bit s1 = 0, s16 = 0;
    @(negedge clk);
    x_a = ta; x_b = tb_; x_cin = tc; x_sub = ts; x_valid = 1'b1;
    for (int i = 1; i <= 40 && !(s1 && s16); i++) begin
      @(negedge clk);
      x_valid = 1'b0;
      x_a = ~ta; x_b = ~tb_;
      if (!s16 && r16_out_valid) begin
        s16 = 1;
        check({tag, "_d16_lat"}, i - 1, 1);
        check({tag, "_d16_res"}, {r16_cout, r16_ovf, r16_sum}, exp);
      end
      if (!s1 && r1_out_valid) begin
        s1 = 1;
        check({tag, "_d1_lat"}, i - 1, 16);
        check({tag, "_d1_res"}, {r1_cout, r1_ovf, r1_sum}, exp);
      end
    end
    if (!s1)  check({tag, "_d1_timeout"}, 0, 1);
    if (!s16) check({tag, "_d16_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int c, bad;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [17:0] m;

    rst = 1'b1; in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
    x_valid = 0; x_a = 0; x_b = 0; x_cin = 0; x_sub = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", {cout, ovf, sum}, 18'd0);
    rst = 1'b0;
    #1 check("idle_in_ready", in_ready, 1'b1);

    // Directed arithmetic on the DIGIT=4 build
    run_op("ffff_p1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("7fff_cin",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("sub_5_7",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_8000",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_cin",   16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("neg_ovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("ripple",    16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Back-pressure in DONE with a competing request held by the source
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; in_valid = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      c++;
    end while (!out_valid && c < 40);
    check("bp_lat", c - 1, 4);
    a = 16'h0101; b = 16'h0202; in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid && !in_ready && sum == 16'h3333 && !cout && !ovf)) bad++;
    end
    check("bp_hold", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    c = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      c++;
    end while (!out_valid && c < 40);
    check("bp_next_lat", c, 5);
    check("bp_next_sum", sum, 16'h0303);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the second BUSY cycle abandons the operation
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 0; sub = 0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("midrst_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", {cout, ovf, sum}, 18'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("midrst_no_result", bad, 0);
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Bit-serial and single-cycle builds
    run_multi("m_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    run_multi("m_7fff", 16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h8000});
    run_multi("m_sub8", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    run_multi("m_sub5", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    run_multi("m_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});

    // A handful of random operands against the reference model
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      m  = model(ra, rb, rc, rs);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, m[15:0], m[17], m[16]);
      run_multi($sformatf("mrnd%0d", i), ra, rb, rc, rs, m);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
